// File: rtl/pfd_ctrl_pkg.sv
// Shared types, output codes and parameter defaults for the PFD loop controller.
package pfd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_ACQ    = 3'd2,
        ST_TRACK  = 3'd3,
        ST_LOCKED = 3'd4
    } pfd_state_t;

    localparam logic [1:0] GAIN_OFF  = 2'b00;
    localparam logic [1:0] GAIN_HIGH = 2'b10;
    localparam logic [1:0] GAIN_LOW  = 2'b01;

    localparam int DEF_CNT_W      = 8;
    localparam int DEF_FLUSH_CYC  = 4;
    localparam int DEF_TRACK_TOL  = 16;
    localparam int DEF_LOCK_TOL   = 2;
    localparam int DEF_LOCK_CNT   = 8;
    localparam int DEF_UNLOCK_CNT = 4;
    localparam int DEF_TIMEOUT    = 1024;

    // States in which the PFD runs and its pulses are measured.
    function automatic logic is_run_state(pfd_state_t s);
        return (s == ST_ACQ) || (s == ST_TRACK) || (s == ST_LOCKED);
    endfunction

endpackage

// File: rtl/pfd_loop_ctrl_if.sv
// Measurement channel between the loop FSM (master) and the up/down pulse counter (slave).
interface pfd_loop_ctrl_if
    import pfd_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic                    up;
    logic                    down;
    logic                    ref_tick;
    logic                    cnt_en;
    logic signed [CNT_W:0]   err;
    logic                    err_valid;

    modport master (output up, down, ref_tick, cnt_en, input err, err_valid);
    modport slave  (input up, down, ref_tick, cnt_en, output err, err_valid);
endinterface

// File: rtl/pfd_loop_ctrl_meas.sv
// Per-reference-period up/down pulse counter; produces a signed phase error on each ref_tick.
module pfd_loop_ctrl_meas
    import pfd_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input logic              clk,
    input logic              rst,
    pfd_loop_ctrl_if.slave   mif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             up_s;
    logic             dn_s;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] dn_cnt;
    logic [CNT_W-1:0] up_nxt;
    logic [CNT_W-1:0] dn_nxt;

    sync2 u_sync_up (.clk(clk), .rst(rst), .d(mif.up),   .q(up_s));
    sync2 u_sync_dn (.clk(clk), .rst(rst), .d(mif.down), .q(dn_s));

    // The tick cycle's own sample belongs to the window it closes.
    always_comb begin
        up_nxt = up_cnt;
        dn_nxt = dn_cnt;
        if (up_s && (up_cnt != CNT_MAX)) up_nxt = up_cnt + CNT_ONE;
        if (dn_s && (dn_cnt != CNT_MAX)) dn_nxt = dn_cnt + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_cnt        <= '0;
            dn_cnt        <= '0;
            mif.err       <= '0;
            mif.err_valid <= 1'b0;
        end else begin
            mif.err_valid <= 1'b0;
            if (!mif.cnt_en) begin
                up_cnt <= '0;
                dn_cnt <= '0;
            end else if (mif.ref_tick) begin
                up_cnt        <= '0;
                dn_cnt        <= '0;
                mif.err       <= $signed({1'b0, up_nxt}) - $signed({1'b0, dn_nxt});
                mif.err_valid <= 1'b1;
            end else begin
                up_cnt <= up_nxt;
                dn_cnt <= dn_nxt;
            end
        end
    end
endmodule

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pfd_loop_ctrl.sv
// PFD loop sequencer: flush, acquire, track and lock on measured phase error.
// Define PFD_CTRL_STATS_EN to build the saturating lock-loss event counter.
//
// state  | meaning
// IDLE   | loop off, PFD held in reset, gain off
// FLUSH  | PFD held in reset for FLUSH_CYC cycles
// ACQ    | coarse acquisition, high gain
// TRACK  | fine tracking, low gain, counting toward lock
// LOCKED | lock declared, low gain, counting toward lock loss
module pfd_loop_ctrl
    import pfd_ctrl_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FLUSH_CYC  = DEF_FLUSH_CYC,
    parameter int TRACK_TOL  = DEF_TRACK_TOL,
    parameter int LOCK_TOL   = DEF_LOCK_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  down,
    input  logic                  ref_tick,
    output logic                  pfd_rst_n,
    output logic [1:0]            gain_sel,
    output logic                  locked,
    output logic [2:0]            state,
    output logic signed [CNT_W:0] err,
    output logic                  err_valid,
    output logic                  ref_lost,
    output logic [7:0]            lock_loss_cnt
);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int FL_W = $clog2(FLUSH_CYC + 1);
    localparam int LK_W = $clog2(LOCK_CNT + 1);
    localparam int UL_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [TO_W-1:0]  TO_LOAD      = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_ONE       = TO_W'(1);
    localparam logic [FL_W-1:0]  FL_LOAD      = FL_W'(FLUSH_CYC - 1);
    localparam logic [FL_W-1:0]  FL_ONE       = FL_W'(1);
    localparam logic [LK_W-1:0]  LK_LOAD      = LK_W'(LOCK_CNT - 1);
    localparam logic [LK_W-1:0]  LK_ONE       = LK_W'(1);
    localparam logic [UL_W-1:0]  UL_LOAD      = UL_W'(UNLOCK_CNT - 1);
    localparam logic [UL_W-1:0]  UL_ONE       = UL_W'(1);
    localparam logic [CNT_W:0]   TRACK_TOL_V  = (CNT_W + 1)'(TRACK_TOL);
    localparam logic [CNT_W:0]   LOCK_TOL_V   = (CNT_W + 1)'(LOCK_TOL);

    pfd_state_t      cur_state;
    pfd_state_t      nxt_state;
    logic [TO_W-1:0] to_cnt;
    logic [FL_W-1:0] fl_cnt;
    logic [LK_W-1:0] lk_cnt;
    logic [UL_W-1:0] ul_cnt;
    logic [CNT_W:0]  err_mag;
    logic            in_run;
    logic            ev;
    logic            in_track_tol;
    logic            in_lock_tol;
    logic            timeout_hit;

    pfd_loop_ctrl_if #(.CNT_W(CNT_W)) mif ();

    assign mif.up       = up;
    assign mif.down     = down;
    assign mif.ref_tick = ref_tick;
    assign mif.cnt_en   = in_run;

    pfd_loop_ctrl_meas #(.CNT_W(CNT_W)) u_meas (
        .clk (clk),
        .rst (rst),
        .mif (mif)
    );

    assign err          = mif.err;
    assign err_valid    = mif.err_valid;
    assign ev           = mif.err_valid;
    assign err_mag      = mif.err[CNT_W] ? -mif.err : mif.err;
    assign in_track_tol = (err_mag <= TRACK_TOL_V);
    assign in_lock_tol  = (err_mag <= LOCK_TOL_V);
    assign in_run       = is_run_state(cur_state);
    // A tick landing on the terminal count still counts as arriving in time.
    assign timeout_hit  = in_run && (to_cnt == '0) && !ref_tick;
    assign state        = cur_state;

    always_ff @(posedge clk) begin
        if (rst) cur_state <= ST_IDLE;
        else     cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        pfd_rst_n = 1'b0;
        gain_sel  = GAIN_OFF;
        locked    = 1'b0;
        ref_lost  = 1'b0;
        case (cur_state)
            ST_ACQ:    begin pfd_rst_n = 1'b1; gain_sel = GAIN_HIGH; end
            ST_TRACK:  begin pfd_rst_n = 1'b1; gain_sel = GAIN_LOW;  end
            ST_LOCKED: begin pfd_rst_n = 1'b1; gain_sel = GAIN_LOW; locked = 1'b1; end
            default:   ;
        endcase
        if (!enable) begin
            nxt_state = ST_IDLE;
        end else if (timeout_hit) begin
            nxt_state = ST_FLUSH;
            ref_lost  = 1'b1;
        end else begin
            case (cur_state)
                ST_IDLE:   nxt_state = ST_FLUSH;
                ST_FLUSH:  if (fl_cnt == '0) nxt_state = ST_ACQ;
                ST_ACQ:    if (ev && in_track_tol) nxt_state = ST_TRACK;
                ST_TRACK: begin
                    if (ev && !in_track_tol)                   nxt_state = ST_ACQ;
                    else if (ev && in_lock_tol && lk_cnt == '0) nxt_state = ST_LOCKED;
                end
                ST_LOCKED: if (ev && !in_lock_tol && ul_cnt == '0) nxt_state = ST_TRACK;
                default:   nxt_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= TO_LOAD;
            fl_cnt <= FL_LOAD;
            lk_cnt <= LK_LOAD;
            ul_cnt <= UL_LOAD;
        end else begin
            if (!in_run || ref_tick)  to_cnt <= TO_LOAD;
            else if (to_cnt != '0)    to_cnt <= to_cnt - TO_ONE;

            if (cur_state != ST_FLUSH) fl_cnt <= FL_LOAD;
            else if (fl_cnt != '0)     fl_cnt <= fl_cnt - FL_ONE;

            // Run counters reload whenever the streak they measure is broken.
            if (cur_state != ST_TRACK) begin
                lk_cnt <= LK_LOAD;
            end else if (ev) begin
                if (!in_lock_tol)        lk_cnt <= LK_LOAD;
                else if (lk_cnt != '0)   lk_cnt <= lk_cnt - LK_ONE;
            end

            if (cur_state != ST_LOCKED) begin
                ul_cnt <= UL_LOAD;
            end else if (ev) begin
                if (in_lock_tol)         ul_cnt <= UL_LOAD;
                else if (ul_cnt != '0)   ul_cnt <= ul_cnt - UL_ONE;
            end
        end
    end

`ifdef PFD_CTRL_STATS_EN
    logic [7:0] loss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= 8'd0;
        end else if ((cur_state == ST_LOCKED)
                     && ((nxt_state == ST_TRACK) || (nxt_state == ST_FLUSH))
                     && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pfd_loop_ctrl.sv
// Self-checking bench for pfd_loop_ctrl against a per-period behavioural model.
module tb_pfd_loop_ctrl;
    import pfd_ctrl_pkg::*;

    localparam int CNT_W      = 8;
    localparam int FLUSH_CYC  = 4;
    localparam int TRACK_TOL  = 16;
    localparam int LOCK_TOL   = 2;
    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_CNT = 4;
    localparam int TIMEOUT    = 1024;
    localparam int PER_LEN    = 99;
    localparam int SAT        = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       pfd_rst_n;
    logic [1:0] gain_sel;
    logic       locked;
    logic [2:0] state;
    logic       ref_lost;
    logic [7:0] lock_loss_cnt;

    pfd_loop_ctrl_if #(.CNT_W(CNT_W)) tb_if ();
    assign tb_if.cnt_en = enable;

    pfd_loop_ctrl #(
        .CNT_W(CNT_W), .FLUSH_CYC(FLUSH_CYC), .TRACK_TOL(TRACK_TOL), .LOCK_TOL(LOCK_TOL),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .up            (tb_if.up),
        .down          (tb_if.down),
        .ref_tick      (tb_if.ref_tick),
        .pfd_rst_n     (pfd_rst_n),
        .gain_sel      (gain_sel),
        .locked        (locked),
        .state         (state),
        .err           (tb_if.err),
        .err_valid     (tb_if.err_valid),
        .ref_lost      (ref_lost),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: loop state and streak lengths, advanced once per measured error.
    int m_state, m_run, m_unl, m_loss, carry_up, carry_dn;

    task automatic check_val(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_gain(input int s);
        if (s == int'(ST_ACQ)) return 2;
        if (s == int'(ST_TRACK) || s == int'(ST_LOCKED)) return 1;
        return 0;
    endfunction

    function automatic int abs_i(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_err(input int e);
        int mag;
        mag = abs_i(e);
        if (m_state == int'(ST_ACQ)) begin
            if (mag <= TRACK_TOL) begin m_state = int'(ST_TRACK); m_run = 0; end
        end else if (m_state == int'(ST_TRACK)) begin
            if (mag > TRACK_TOL) m_state = int'(ST_ACQ);
            else if (mag <= LOCK_TOL) begin
                m_run++;
                if (m_run == LOCK_CNT) begin m_state = int'(ST_LOCKED); m_unl = 0; end
            end else m_run = 0;
        end else if (m_state == int'(ST_LOCKED)) begin
            if (mag > LOCK_TOL) begin
                m_unl++;
                if (m_unl == UNLOCK_CNT) begin
                    m_state = int'(ST_TRACK);
                    m_run = 0;
                    if (m_loss < 255) m_loss++;
                end
            end else m_unl = 0;
        end
    endtask

    task automatic check_status(input string tag);
        int el;
`ifdef PFD_CTRL_STATS_EN
        el = m_loss;
`else
        el = 0;
`endif
        check_val({tag, "_state"}, int'(state), m_state);
        check_val({tag, "_locked"}, int'(locked), (m_state == int'(ST_LOCKED)) ? 1 : 0);
        check_val({tag, "_gain"}, int'(gain_sel), exp_gain(m_state));
        check_val({tag, "_pfd_rst_n"}, int'(pfd_rst_n), (m_state >= int'(ST_ACQ)) ? 1 : 0);
        check_val({tag, "_loss_cnt"}, int'(lock_loss_cnt), el);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_state"}, int'(state), int'(ST_IDLE));
        check_val({tag, "_pfd_rst_n"}, int'(pfd_rst_n), 0);
        check_val({tag, "_gain"}, int'(gain_sel), 0);
        check_val({tag, "_locked"}, int'(locked), 0);
        check_val({tag, "_err"}, int'(tb_if.err), 0);
        check_val({tag, "_err_valid"}, int'(tb_if.err_valid), 0);
        check_val({tag, "_ref_lost"}, int'(ref_lost), 0);
        check_val({tag, "_loss_cnt"}, int'(lock_loss_cnt), 0);
    endtask

    // Waits for FLUSH, measures its length, then expects ACQ.
    task automatic do_flush(input string tag);
        int n = 0, g = 0, bad = 0, ev = 0;
        @(posedge clk); #1;
        while (state != 3'(ST_FLUSH) && g < 10) begin g++; @(posedge clk); #1; end
        while (state == 3'(ST_FLUSH) && n < 50) begin
            n++;
            if (pfd_rst_n !== 1'b0 || gain_sel !== 2'b00 || ref_lost !== 1'b0) bad++;
            if (tb_if.err_valid) ev++;
            @(posedge clk); #1;
        end
        check_val({tag, "_flush_len"}, n, FLUSH_CYC);
        check_val({tag, "_flush_outs"}, bad, 0);
        check_val({tag, "_flush_ev"}, ev, 0);
        check_val({tag, "_acq_state"}, int'(state), int'(ST_ACQ));
        check_val({tag, "_acq_gain"}, int'(gain_sel), 2);
        check_val({tag, "_acq_pfd_rst_n"}, int'(pfd_rst_n), 1);
        m_state = int'(ST_ACQ); m_run = 0; m_unl = 0; carry_up = 0; carry_dn = 0;
    endtask

    // One reference period: up high over [su,su+ul), down over [sd,sd+dl), tick on the last cycle.
    // Pulses driven in the last two cycles reach the counters only after the tick.
    task automatic run_period(input int su, input int ul, input int sd, input int dl, input int len);
        int wu, wd, nu = 0, nd = 0, ev_seen = 0, rl_seen = 0, experr;
        logic uh, dh;
        wu = carry_up;
        wd = carry_dn;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 0) check_status("period");
            if (tb_if.err_valid) ev_seen++;
            if (ref_lost) rl_seen++;
            uh = (i >= su) && (i < su + ul);
            dh = (i >= sd) && (i < sd + dl);
            tb_if.up = uh;
            tb_if.down = dh;
            tb_if.ref_tick = (i == len - 1);
            if (uh) begin if (i <= len - 3) wu++; else nu++; end
            if (dh) begin if (i <= len - 3) wd++; else nd++; end
        end
        @(posedge clk); #1;
        tb_if.up = 1'b0;
        tb_if.down = 1'b0;
        tb_if.ref_tick = 1'b0;
        experr = ((wu > SAT) ? SAT : wu) - ((wd > SAT) ? SAT : wd);
        check_val("window_quiet", ev_seen, 0);
        check_val("window_ref_lost", rl_seen, 0);
        check_val("err_valid", int'(tb_if.err_valid), 1);
        check_val("err", int'(tb_if.err), experr);
        carry_up = nu;
        carry_dn = nd;
        model_err(experr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int su, ul, sd, dl, g, hit;
        m_state = int'(ST_IDLE); m_run = 0; m_unl = 0; m_loss = 0; carry_up = 0; carry_dn = 0;
        rst = 1'b1;
        enable = 1'b0;
        tb_if.up = 1'b0;
        tb_if.down = 1'b0;
        tb_if.ref_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("idle_hold", int'(state), int'(ST_IDLE));

        enable = 1'b1;
        do_flush("start");

        // Lock acquisition: +30, +10, then +1 until locked.
        repeat (2) run_period(2, 30, 0, 0, PER_LEN);
        repeat (2) run_period(2, 10, 0, 0, PER_LEN);
        repeat (LOCK_CNT) run_period(2, 1, 0, 0, PER_LEN);
        @(posedge clk); #1;
        check_val("acq_locked", int'(locked), 1);
        check_val("acq_locked_state", int'(state), int'(ST_LOCKED));

        // Lock loss: -5 per period.
        repeat (UNLOCK_CNT) run_period(0, 0, 2, 5, PER_LEN);
        @(posedge clk); #1;
        check_val("loss_locked", int'(locked), 0);
        check_val("loss_state", int'(state), int'(ST_TRACK));
        check_status("loss");

        // Relock, then stop the reference.
        repeat (LOCK_CNT) run_period(2, 1, 0, 0, PER_LEN);
        hit = -1;
        for (int k = 1; k <= TIMEOUT + 20; k++) begin
            @(posedge clk); #1;
            if (ref_lost) begin
                hit = k;
                check_val("timeout_state", int'(state), int'(ST_LOCKED));
                break;
            end
        end
        check_val("timeout_cycle", hit, TIMEOUT - 1);
        if (m_loss < 255) m_loss++;
        do_flush("timeout");

        // Counter saturation in both directions.
        run_period(0, 300, 0, 0, 310);
        run_period(0, 0, 0, 300, 310);

        // Randomized periods, including pulses that straddle the tick.
        for (int p = 0; p < 16; p++) begin
            su = $urandom_range(0, PER_LEN - 1);
            ul = $urandom_range(0, 40);
            sd = $urandom_range(0, PER_LEN - 1);
            dl = $urandom_range(0, 40);
            run_period(su, ul, sd, dl, PER_LEN);
        end

        // Enable drop coinciding with err_valid in TRACK.
        g = 0;
        while (m_state != int'(ST_TRACK) && g < 8) begin
            run_period(2, 5, 0, 0, PER_LEN);
            g++;
        end
        run_period(2, 5, 0, 0, PER_LEN);
        enable = 1'b0;
        @(posedge clk); #1;
        check_val("drop_state", int'(state), int'(ST_IDLE));
        check_val("drop_gain", int'(gain_sel), 0);
        check_val("drop_pfd_rst_n", int'(pfd_rst_n), 0);
        check_val("drop_locked", int'(locked), 0);

        // Reset 50 cycles into a window.
        enable = 1'b1;
        do_flush("rerun");
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            tb_if.up = (i >= 2) && (i < 32);
        end
        rst = 1'b1;
        tb_if.up = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals("midrst");
        m_loss = 0;
        do_flush("midrst");
        run_period(2, 7, 0, 0, PER_LEN);
        @(posedge clk); #1;
        check_status("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pfd_loop_ctrl.md
PFD_LOOP_CTRL -- requirements
Module: pfd_loop_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the per-period up/down pulse counters.
REQ-002 SHALL have parameter FLUSH_CYC, default 4: number of cycles the PFD is held in reset on entry to FLUSH.
REQ-003 SHALL have parameter TRACK_TOL, default 16: |err| threshold for moving from ACQ to TRACK.
REQ-004 SHALL have parameter LOCK_TOL, default 2: |err| threshold counted toward lock.
REQ-005 SHALL have parameter LOCK_CNT, default 8: consecutive in-tolerance periods required to declare lock.
REQ-006 SHALL have parameter UNLOCK_CNT, default 4: consecutive out-of-tolerance periods required to declare lock loss.
REQ-007 SHALL have parameter TIMEOUT, default 1024: maximum cycles between ref_tick pulses before the reference is declared lost.
REQ-008 SHALL have port clk, input, 1 bit: single system clock; one clock; every flop in the block is clocked by it.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port enable, input, 1 bit: loop run request.
REQ-011 SHALL have port up, input, 1 bit: PFD "speed up" output; asynchronous to clk.
REQ-012 SHALL have port down, input, 1 bit: PFD "slow down" output; asynchronous to clk.
REQ-013 SHALL have port ref_tick, input, 1 bit: one-cycle pulse in the clk domain, once per reference period.
REQ-014 SHALL have port pfd_rst_n, output, 1 bit: drives the PFD global reset; 0 holds the PFD cleared.
REQ-015 SHALL have port gain_sel, output, 2 bits: loop-filter gain code (00 off, 10 high, 01 low).
REQ-016 SHALL have port locked, output, 1 bit: loop lock indication.
REQ-017 SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-018 SHALL have port err, output, CNT_W+1 bits, signed: last measured phase error, up_cnt - dn_cnt.
REQ-019 SHALL have port err_valid, output, 1 bit: one-cycle strobe marking a new err.
REQ-020 SHALL have port ref_lost, output, 1 bit: one-cycle strobe when the timeout fires.
REQ-021 SHALL have port lock_loss_cnt, output, 8 bits: count of lock-loss events (see Configuration).

Function
REQ-022 SHALL pass up and down each through a 2-flop synchronizer, giving 2-cycle latency before counting.
REQ-023 SHALL increment up_cnt on each cycle the synced up is 1, and dn_cnt on each cycle the synced down is 1, saturating each at 2^CNT_W-1; counting is active only in ACQ, TRACK and LOCKED.
REQ-024 SHALL, on a ref_tick cycle, include that cycle's sample, register err = up_cnt - dn_cnt, pulse err_valid on the next cycle, and clear both counters.
REQ-025 SHALL implement FSM states IDLE=0, FLUSH=1, ACQ=2, TRACK=3, LOCKED=4; each transition is evaluated in the err_valid cycle and takes effect on the next cycle.
REQ-026 SHALL set outputs per state: IDLE has pfd_rst_n=0 and gain 00; FLUSH has pfd_rst_n=0 and gain 00; ACQ has gain 10; TRACK has gain 01; LOCKED has gain 01 and locked=1.
REQ-027 SHALL move IDLE to FLUSH when enable=1, and FLUSH to ACQ after exactly FLUSH_CYC cycles.
REQ-028 SHALL move ACQ to TRACK on the first err with |err|<=TRACK_TOL.
REQ-029 SHALL move TRACK to ACQ if |err|>TRACK_TOL.
REQ-030 SHALL move TRACK to LOCKED after LOCK_CNT consecutive errs with |err|<=LOCK_TOL; any err above LOCK_TOL clears the run counter.
REQ-031 SHALL move LOCKED to TRACK after UNLOCK_CNT consecutive errs with |err|>LOCK_TOL, deasserting locked in the same cycle as the transition.
REQ-032 SHALL, in ACQ, TRACK or LOCKED, go to FLUSH and pulse ref_lost once TIMEOUT cycles elapse with no ref_tick.
REQ-033 SHALL go to IDLE on the next cycle when enable=0, from any state, with priority over every other transition.
REQ-034 SHALL let a ref_tick that coincides with the timeout count as an arriving tick, so no timeout fires.

Reset
REQ-035 SHALL, with rst=1 at a clk edge, force state=IDLE, pfd_rst_n=0, gain_sel=00, locked=0, err=0, err_valid=0, ref_lost=0, lock_loss_cnt=0, and clear all counters and synchronizers.
REQ-036 SHALL discard any in-progress measurement when reset is asserted mid-operation, with no err_valid after reset release until a full window completes.

Configuration
REQ-037 SHALL, with macro PFD_CTRL_STATS_EN defined, increment lock_loss_cnt (saturating at 255) on each LOCKED-to-TRACK or LOCKED-to-FLUSH transition.
REQ-038 SHALL, without PFD_CTRL_STATS_EN, tie lock_loss_cnt to 0 and instantiate no counter logic.

Structure
REQ-039 SHALL place state encodings, gain codes and parameter defaults in a shared package pfd_ctrl_pkg.
REQ-040 SHALL implement the synchronizer as sub-module sync2, instantiated twice (up, down).

Verification
REQ-041 SHALL cover lock acquisition: enable=1, ref_tick every 100 cycles, up held 30 cycles per period, then 10, then 1 -> state sequence FLUSH(4 cycles), ACQ, TRACK, then locked=1 after the 8th in-tolerance err; err values +30, +10, +1.
REQ-042 SHALL cover lock loss: while LOCKED, down held 5 cycles per period -> locked drops after the 4th err of -5; lock_loss_cnt=1 with the macro, 0 without.
REQ-043 SHALL cover timeout: stop ref_tick in LOCKED -> ref_lost pulses at cycle 1024, state goes to FLUSH, pfd_rst_n=0 for 4 cycles.
REQ-044 SHALL cover saturation: up held constant for a 300-cycle period with CNT_W=8 -> err=+255.
REQ-045 SHALL cover enable drop: enable=0 in the same cycle as err_valid in TRACK -> next cycle state=IDLE, gain_sel=00, pfd_rst_n=0.
REQ-046 SHALL cover reset mid-window: rst pulse 50 cycles into a period -> all outputs at reset values and no err_valid until the next full window closes.
